// File: rtl/pixel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_scheduler
//  Purpose  : Walks a frame in raster order, issues one c coordinate per
//             pixel to the Mandelbrot iteration engine, captures its result
//             and hands each pixel to the sink over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module pixel_scheduler #(
    parameter int FIXED_POINT_WIDTH = 16,
    parameter int MAX_ITER          = 256,
    parameter int H_RES             = 320,
    parameter int V_RES             = 240,
    parameter logic signed [FIXED_POINT_WIDTH-1:0] X_START = 16'hE000,
    parameter logic signed [FIXED_POINT_WIDTH-1:0] Y_START = 16'h1000,
    parameter logic signed [FIXED_POINT_WIDTH-1:0] STEP    = 16'h0010,
    localparam int IW = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1,
    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1,
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                go,
    output logic                                mb_start,
    output logic signed [FIXED_POINT_WIDTH-1:0] mb_c_real,
    output logic signed [FIXED_POINT_WIDTH-1:0] mb_c_imaginary,
    input  logic                                mb_valid,
    input  logic                                mb_is_mandelbrot,
    input  logic [IW-1:0]                       mb_iterations,
    output logic                                px_valid,
    input  logic                                px_ready,
    output logic [XW-1:0]                       px_x,
    output logic [YW-1:0]                       px_y,
    output logic [IW-1:0]                       px_iterations,
    output logic                                px_in_set,
    output logic                                busy,
    output logic                                frame_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [XW-1:0] c_X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] c_Y_LAST = YW'(V_RES - 1);

    logic [2:0]                          r_state;
    logic [2:0]                          w_state_next;
    logic                                w_xfer;
    logic [XW-1:0]                       r_x;
    logic [YW-1:0]                       r_y;
    logic signed [FIXED_POINT_WIDTH-1:0] r_c_real;
    logic signed [FIXED_POINT_WIDTH-1:0] r_c_imag;
    logic [IW-1:0]                       r_iter;
    logic                                r_in_set;
    logic                                r_mb_start;
    logic                                r_px_valid;
    logic                                r_busy;
    logic                                r_frame_done;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a transfer is EMIT with ready (px_valid mirrors EMIT).
    always_comb begin
        w_state_next = r_state;
        w_xfer       = 1'b0;
        case (r_state)
            S_IDLE:  if (go) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            // The ISSUE cycle never looks at mb_valid, so a stale valid
            // still held from the previous pixel cannot be captured.
            S_WAIT:  if (mb_valid) w_state_next = S_EMIT;
            S_EMIT: begin
                if (px_ready) begin
                    w_xfer = 1'b1;
                    if ((r_x == c_X_LAST) && (r_y == c_Y_LAST)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Registered outputs and raster/coordinate datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mb_start   <= 1'b0;
            r_px_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_c_real     <= '0;
            r_c_imag     <= '0;
            r_iter       <= '0;
            r_in_set     <= 1'b0;
        end else begin
            // Outputs are decoded from the next state so they line up with it.
            r_mb_start   <= (w_state_next == S_ISSUE);
            r_px_valid   <= (w_state_next == S_EMIT);
            r_busy       <= (w_state_next != S_IDLE);
            r_frame_done <= (w_state_next == S_DONE);

            if ((r_state == S_IDLE) && go) begin
                r_x      <= '0;
                r_y      <= '0;
                r_c_real <= X_START;
                r_c_imag <= Y_START;
            end

            if ((r_state == S_WAIT) && mb_valid) begin
                r_iter   <= mb_iterations;
                r_in_set <= mb_is_mandelbrot;
            end

            // Coordinates wrap silently in two's complement.
            if (w_xfer) begin
                if (r_x != c_X_LAST) begin
                    r_x      <= r_x + XW'(1);
                    r_c_real <= r_c_real + STEP;
                end else if (r_y != c_Y_LAST) begin
                    r_x      <= '0;
                    r_c_real <= X_START;
                    r_y      <= r_y + YW'(1);
                    r_c_imag <= r_c_imag - STEP;
                end
            end
        end
    end

    assign mb_start       = r_mb_start;
    assign mb_c_real      = r_c_real;
    assign mb_c_imaginary = r_c_imag;
    assign px_valid       = r_px_valid;
    assign px_x           = r_x;
    assign px_y           = r_y;
    assign px_iterations  = r_iter;
    assign px_in_set      = r_in_set;
    assign busy           = r_busy;
    assign frame_done     = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_scheduler
//  Purpose  : Self-checking bench for pixel_scheduler with a randomized
//             engine model and a raster-order reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pixel_scheduler;

    localparam int          HR   = 3;
    localparam int          VR   = 2;
    localparam int          NPIX = HR * VR;
    localparam logic [15:0] X0   = 16'h7F00;
    localparam logic [15:0] Y0   = 16'h8000;
    localparam logic [15:0] ST   = 16'h0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        mb_start;
    logic signed [15:0] mb_c_real;
    logic signed [15:0] mb_c_imaginary;
    logic        mb_valid;
    logic        mb_is_mandelbrot;
    logic [3:0]  mb_iterations;
    logic        px_valid;
    logic        px_ready;
    logic [1:0]  px_x;
    logic [0:0]  px_y;
    logic [3:0]  px_iterations;
    logic        px_in_set;
    logic        busy;
    logic        frame_done;

    pixel_scheduler #(
        .FIXED_POINT_WIDTH(16), .MAX_ITER(16), .H_RES(HR), .V_RES(VR),
        .X_START(X0), .Y_START(Y0), .STEP(ST)
    ) dut (
        .clk(clk), .rst(rst), .go(go),
        .mb_start(mb_start), .mb_c_real(mb_c_real), .mb_c_imaginary(mb_c_imaginary),
        .mb_valid(mb_valid), .mb_is_mandelbrot(mb_is_mandelbrot), .mb_iterations(mb_iterations),
        .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
        .px_iterations(px_iterations), .px_in_set(px_in_set),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pixel idx in raster order has c = start + x*STEP, start - y*STEP.
    function automatic logic [15:0] exp_re(input int idx);
        return 16'(int'(X0) + (idx % HR) * int'(ST));
    endfunction
    function automatic logic [15:0] exp_im(input int idx);
        return 16'(int'(Y0) - (idx / HR) * int'(ST));
    endfunction

    // Engine model state
    bit         eng_stuck = 1'b0;
    int         eng_dmin = 0, eng_dmax = 0;
    bit         eng_pending = 1'b0;
    int         eng_cnt = 0;
    logic [3:0] eng_it;
    bit         eng_set;
    logic [3:0] exp_it = '0;
    bit         exp_set = 1'b0;

    // Engine: answers each mb_start after a random delay; optionally keeps valid high.
    initial begin
        mb_valid = 1'b0; mb_is_mandelbrot = 1'b0; mb_iterations = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                eng_pending = 1'b0;
                mb_valid    = 1'b0;
            end else begin
                if (eng_pending) begin
                    if (eng_cnt == 0) begin
                        mb_valid = 1'b1; mb_iterations = eng_it; mb_is_mandelbrot = eng_set;
                        exp_it = eng_it; exp_set = eng_set;
                        eng_pending = 1'b0;
                    end else begin
                        eng_cnt--;
                        mb_valid = 1'b0;
                    end
                end else if (!eng_stuck) begin
                    mb_valid = 1'b0;
                end
                if (mb_start === 1'b1) begin
                    eng_pending = 1'b1;
                    eng_cnt     = int'($urandom_range(eng_dmax, eng_dmin));
                    eng_it      = mb_iterations ^ 4'($urandom_range(15, 1));
                    eng_set     = 1'($urandom_range(1, 0));
                end
            end
        end
    end

    // Sink ready driver: 0 = hold low, 1 = always ready, 2 = random.
    int ready_mode = 1;
    initial begin
        px_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       px_ready = 1'b0;
                1:       px_ready = 1'b1;
                default: px_ready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    // Monitor state
    int          pix_idx = 0, xfers = 0, starts = 0, frames = 0;
    bit          outstanding = 1'b0, hold = 1'b0, prev_done = 1'b0;
    logic [15:0] held_re, held_im;
    logic [1:0]  h_x;
    logic [0:0]  h_y;
    logic [3:0]  h_it;
    logic        h_set;
    logic [15:0] c_log_re [8];
    logic [15:0] c_log_im [8];
    int          c_log_n = 0;

    // Continuous protocol and raster-order checking against the model.
    always @(negedge clk) begin
        if (rst) begin
            pix_idx = 0; outstanding = 1'b0; hold = 1'b0; prev_done = 1'b0;
        end else begin
            if (hold) begin
                checks++;
                if (px_valid !== 1'b1 || px_x !== h_x || px_y !== h_y || px_iterations !== h_it ||
                    px_in_set !== h_set || mb_start !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%b x=%0d y=%0d it=%0d set=%b start=%b, want 1 %0d %0d %0d %b 0",
                             px_valid, px_x, px_y, px_iterations, px_in_set, mb_start, h_x, h_y, h_it, h_set);
                end
            end
            if (mb_start === 1'b1) begin
                checks++;
                if (outstanding) begin
                    errors++;
                    $display("FAIL single_start: got second mb_start for pixel %0d, want one", pix_idx);
                end
                checks++;
                if (mb_c_real !== exp_re(pix_idx) || mb_c_imaginary !== exp_im(pix_idx)) begin
                    errors++;
                    $display("FAIL c_value: pixel %0d got (%h,%h), want (%h,%h)", pix_idx,
                             mb_c_real, mb_c_imaginary, exp_re(pix_idx), exp_im(pix_idx));
                end
                if (c_log_n < 8) begin
                    c_log_re[c_log_n] = mb_c_real;
                    c_log_im[c_log_n] = mb_c_imaginary;
                    c_log_n++;
                end
                starts++;
                outstanding = 1'b1;
                held_re = mb_c_real;
                held_im = mb_c_imaginary;
            end else if (outstanding) begin
                checks++;
                if (mb_c_real !== held_re || mb_c_imaginary !== held_im) begin
                    errors++;
                    $display("FAIL c_stable: got (%h,%h), want (%h,%h)", mb_c_real, mb_c_imaginary, held_re, held_im);
                end
            end
            if (px_valid === 1'b1) begin
                checks++;
                if (!outstanding) begin
                    errors++;
                    $display("FAIL valid_no_request: got px_valid=1 with no pixel issued, want 0");
                end
                if (px_ready === 1'b1) begin
                    checks++;
                    if (px_x !== 2'(pix_idx % HR) || px_y !== 1'(pix_idx / HR) ||
                        px_iterations !== exp_it || px_in_set !== exp_set) begin
                        errors++;
                        $display("FAIL transfer: got x=%0d y=%0d it=%0d set=%b, want %0d %0d %0d %b",
                                 px_x, px_y, px_iterations, px_in_set, pix_idx % HR, pix_idx / HR, exp_it, exp_set);
                    end
                    pix_idx++;
                    xfers++;
                    outstanding = 1'b0;
                end
            end
            hold  = (px_valid === 1'b1) && (px_ready !== 1'b1);
            h_x   = px_x; h_y = px_y; h_it = px_iterations; h_set = px_in_set;
            if (frame_done === 1'b1) begin
                checks++;
                if (pix_idx != NPIX || prev_done) begin
                    errors++;
                    $display("FAIL frame_done: got pulse after %0d pixels (prev=%b), want %0d pixels single pulse",
                             pix_idx, prev_done, NPIX);
                end
                frames++;
                pix_idx = 0;
            end
            prev_done = (frame_done === 1'b1);
        end
    end

    task automatic wait_frames(input int target, input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk); #1;
            n++;
            if (frames >= target) ok = 1'b1;
        end
    endtask

    task automatic pulse_go();
        @(posedge clk); #1; go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (mb_start !== 1'b0 || px_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got start=%b valid=%b busy=%b done=%b, want 0 0 0 0", mb_start, px_valid, busy, frame_done);
        end
        checks++;
        if (px_x !== '0 || px_y !== '0 || px_iterations !== '0 || px_in_set !== 1'b0 ||
            mb_c_real !== 16'h0000 || mb_c_imaginary !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: got x=%0d y=%0d it=%0d set=%b c=(%h,%h), want all 0",
                     px_x, px_y, px_iterations, px_in_set, mb_c_real, mb_c_imaginary);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || mb_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_go: got busy=%b start=%b, want 0 0", busy, mb_start);
        end
    endtask

    task automatic test_frame();
        int f0, x0, s0;
        bit ok;
        eng_stuck = 1'b0; eng_dmin = 2; eng_dmax = 2; ready_mode = 1;
        f0 = frames; x0 = xfers; s0 = starts; c_log_n = 0;
        pulse_go();
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b1 || mb_start !== 1'b1) begin
            errors++;
            $display("FAIL go_start: got busy=%b start=%b, want 1 1", busy, mb_start);
        end
        repeat (4) @(posedge clk);
        #1; go = 1'b1;
        repeat (2) @(posedge clk);
        #1; go = 1'b0;
        wait_frames(f0 + 1, 400, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_timeout: got %0d frames, want %0d", frames, f0 + 1);
        end
        checks++;
        if (xfers - x0 != NPIX || starts - s0 != NPIX) begin
            errors++;
            $display("FAIL frame_count: got %0d transfers %0d starts, want %0d each", xfers - x0, starts - s0, NPIX);
        end
        checks++;
        if (c_log_re[0] !== 16'h7F00 || c_log_re[1] !== 16'h8000 || c_log_im[3] !== 16'h7F00) begin
            errors++;
            $display("FAIL wrap: got re0=%h re1=%h im3=%h, want 7f00 8000 7f00", c_log_re[0], c_log_re[1], c_log_im[3]);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_done: got %b, want 0", busy);
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (frames != f0 + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL go_ignored_busy: got frames=%0d busy=%b, want %0d 0", frames, busy, f0 + 1);
        end
    endtask

    task automatic test_stuck_valid();
        int f0, x0;
        bit ok;
        eng_stuck = 1'b1; eng_dmin = 0; eng_dmax = 1; ready_mode = 2;
        f0 = frames; x0 = xfers;
        pulse_go();
        wait_frames(f0 + 1, 400, ok);
        checks++;
        if (!ok || xfers - x0 != NPIX) begin
            errors++;
            $display("FAIL stuck_valid: got ok=%b transfers=%0d, want 1 %0d", ok, xfers - x0, NPIX);
        end
        eng_stuck = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int f0, x0, s0, n;
        bit ok;
        logic [1:0] sx;
        logic [3:0] sit;
        eng_dmin = 1; eng_dmax = 1; ready_mode = 0;
        f0 = frames; x0 = xfers;
        pulse_go();
        n = 0;
        while (px_valid !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (px_valid !== 1'b1) begin
            errors++;
            $display("FAIL emit_timeout: got px_valid=%b, want 1", px_valid);
        end
        sx = px_x; sit = px_iterations; s0 = starts;
        repeat (10) begin
            @(negedge clk); #1;
            checks++;
            if (px_valid !== 1'b1 || px_x !== sx || px_iterations !== sit || mb_start !== 1'b0) begin
                errors++;
                $display("FAIL backpressure: got valid=%b x=%0d it=%0d start=%b, want 1 %0d %0d 0",
                         px_valid, px_x, px_iterations, mb_start, sx, sit);
            end
        end
        checks++;
        if (starts != s0 || xfers != x0) begin
            errors++;
            $display("FAIL bp_no_advance: got starts+%0d xfers+%0d, want 0 0", starts - s0, xfers - x0);
        end
        ready_mode = 1;
        wait_frames(f0 + 1, 400, ok);
        checks++;
        if (!ok || xfers - x0 != NPIX) begin
            errors++;
            $display("FAIL bp_release: got ok=%b transfers=%0d, want 1 %0d", ok, xfers - x0, NPIX);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int f0, s0, n;
        bit ok;
        eng_dmin = 0; eng_dmax = 0; ready_mode = 1;
        s0 = starts;
        pulse_go();
        n = 0;
        while (starts < s0 + 2 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        ready_mode = 0;
        n = 0;
        while (px_valid !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (px_valid !== 1'b1 || pix_idx != 1) begin
            errors++;
            $display("FAIL reach_pixel1: got valid=%b idx=%0d, want 1 1", px_valid, pix_idx);
        end
        #1; rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || px_valid !== 1'b0 || mb_start !== 1'b0 || px_x !== '0 || mb_c_real !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got busy=%b valid=%b start=%b x=%0d re=%h, want 0 0 0 0 0000",
                     busy, px_valid, mb_start, px_x, mb_c_real);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        f0 = frames;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (frames != f0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abandon: got frames=%0d busy=%b, want %0d 0", frames, busy, f0);
        end
        ready_mode = 1; c_log_n = 0;
        pulse_go();
        wait_frames(f0 + 1, 400, ok);
        checks++;
        if (!ok || c_log_re[0] !== X0 || c_log_im[0] !== Y0) begin
            errors++;
            $display("FAIL restart: got ok=%b c0=(%h,%h), want 1 (%h,%h)", ok, c_log_re[0], c_log_im[0], X0, Y0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int f0, x0;
        bit ok;
        eng_dmin = 0; eng_dmax = 2; ready_mode = 2;
        f0 = frames; x0 = xfers;
        @(posedge clk); #1; go = 1'b1;
        wait_frames(f0 + 2, 800, ok);
        go = 1'b0;
        checks++;
        if (!ok || xfers - x0 != 2 * NPIX) begin
            errors++;
            $display("FAIL back_to_back: got ok=%b transfers=%0d, want 1 %0d", ok, xfers - x0, 2 * NPIX);
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (frames != f0 + 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: got frames=%0d busy=%b, want %0d 0", frames - f0, busy, 2);
        end
    endtask

    initial begin
        rst = 1'b1; go = 1'b0;
        test_reset();
        test_frame();
        test_stuck_valid();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
